// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multi-cycle MIPS control FSM.
// Opcode/funct values, state encodings, ALU op codes and mux select codes.
package mc_ctrl_pkg;

   localparam int unsigned OP_W = 6;

   // Primary opcodes
   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LB    = 6'h20;
   localparam logic [OP_W-1:0] OP_LH    = 6'h21;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_LBU   = 6'h24;
   localparam logic [OP_W-1:0] OP_LHU   = 6'h25;
   localparam logic [OP_W-1:0] OP_SB    = 6'h28;
   localparam logic [OP_W-1:0] OP_SH    = 6'h29;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [OP_W-1:0] FN_JR    = 6'h08;
   localparam logic [OP_W-1:0] FN_ADDU  = 6'h21;
   localparam logic [OP_W-1:0] FN_SUBU  = 6'h23;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_EXEC   = 4'd2,
      ST_MADDR  = 4'd3,
      ST_MRD    = 4'd4,
      ST_MWR    = 4'd5,
      ST_WB     = 4'd6,
      ST_BRANCH = 4'd7,
      ST_JUMP   = 4'd8
   } state_e;

   localparam logic [2:0] ALU_ADDU = 3'd0;
   localparam logic [2:0] ALU_SUBU = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_LUI  = 3'd3;

   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;
   localparam logic [1:0] REG_DST_RA = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [1:0] PC_PC4 = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;
   localparam logic [1:0] PC_JR  = 2'd3;

   localparam logic [1:0] MW_WORD = 2'd0;
   localparam logic [1:0] MW_HALF = 2'd1;
   localparam logic [1:0] MW_BYTE = 2'd2;

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: combinational instruction-class decode of opcode/funct.
// Optional build macro MC_CTRL_SUBWORD_EN adds lb/lbu/lh/lhu/sb/sh decode.
// Inputs : opcode, funct
// Outputs: instruction class flags, illegal, alu_op for EXEC, ext_sext
//          (+ ld_sext, mem_width when MC_CTRL_SUBWORD_EN is defined)
module mc_ctrl_dec
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic       is_rtype,
   output logic       is_imm,
   output logic       is_load,
   output logic       is_store,
   output logic       is_branch,
   output logic       is_jump,
   output logic       is_jal,
   output logic       is_jr,
   output logic       illegal,
   output logic [2:0] alu_op,
`ifdef MC_CTRL_SUBWORD_EN
   output logic       ld_sext,
   output logic [1:0] mem_width,
`endif
   output logic       ext_sext
);

   always_comb begin
      is_rtype  = 1'b0;
      is_imm    = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jump   = 1'b0;
      is_jal    = 1'b0;
      is_jr     = 1'b0;
      alu_op    = ALU_ADDU;
      ext_sext  = 1'b0;
`ifdef MC_CTRL_SUBWORD_EN
      ld_sext   = 1'b0;
      mem_width = MW_WORD;
`endif
      case (opcode)
         OP_RTYPE: begin
            if (funct == FN_ADDU) begin
               is_rtype = 1'b1;
            end else if (funct == FN_SUBU) begin
               is_rtype = 1'b1;
               alu_op   = ALU_SUBU;
            end else if (funct == FN_JR) begin
               is_jump = 1'b1;
               is_jr   = 1'b1;
            end
         end
         OP_ORI: begin
            is_imm = 1'b1;
            alu_op = ALU_OR;
         end
         OP_LUI: begin
            is_imm = 1'b1;
            alu_op = ALU_LUI;
         end
         OP_LW: begin
            is_load  = 1'b1;
            ext_sext = 1'b1;
         end
         OP_SW: begin
            is_store = 1'b1;
            ext_sext = 1'b1;
         end
         OP_BEQ: begin
            is_branch = 1'b1;
            ext_sext  = 1'b1;
            alu_op    = ALU_SUBU;
         end
         OP_J:   is_jump = 1'b1;
         OP_JAL: begin
            is_jump = 1'b1;
            is_jal  = 1'b1;
         end
`ifdef MC_CTRL_SUBWORD_EN
         // Sub-word accesses reuse the lw/sw paths; address offset stays sign-extended.
         OP_LB, OP_LBU: begin
            is_load   = 1'b1;
            ext_sext  = 1'b1;
            ld_sext   = (opcode == OP_LB);
            mem_width = MW_BYTE;
         end
         OP_LH, OP_LHU: begin
            is_load   = 1'b1;
            ext_sext  = 1'b1;
            ld_sext   = (opcode == OP_LH);
            mem_width = MW_HALF;
         end
         OP_SB: begin
            is_store  = 1'b1;
            ext_sext  = 1'b1;
            mem_width = MW_BYTE;
         end
         OP_SH: begin
            is_store  = 1'b1;
            ext_sext  = 1'b1;
            mem_width = MW_HALF;
         end
`endif
         default: ;
      endcase
      illegal = !(is_rtype || is_imm || is_load || is_store || is_branch || is_jump);
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback from the held IR and drives
// all datapath strobes and selects (Moore outputs from state and ir; the
// BRANCH pc_we follows zero). Outputs are forced low while rst_n is low.
// Optional build macro MC_CTRL_SUBWORD_EN adds sub-word loads/stores and the
// ld_sext / mem_width outputs.
// Inputs : clk, rst_n, ir[31:0], zero, mem_ready
// Outputs: pc_we, ir_we, reg_we, mem_re, mem_we, ext_sext, alu_op[2:0],
//          alu_src_b, reg_dst[1:0], wb_sel[1:0], pc_sel[1:0], bus_err, state[3:0]
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ir,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_we,
   output logic        ir_we,
   output logic        reg_we,
   output logic        mem_re,
   output logic        mem_we,
   output logic        ext_sext,
   output logic [2:0]  alu_op,
   output logic        alu_src_b,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wb_sel,
   output logic [1:0]  pc_sel,
`ifdef MC_CTRL_SUBWORD_EN
   output logic        ld_sext,
   output logic [1:0]  mem_width,
`endif
   output logic        bus_err,
   output logic [3:0]  state
);

   localparam int unsigned CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic               bus_err_q, bus_err_d;
   logic               in_instr;

   logic       dec_is_rtype, dec_is_imm, dec_is_load, dec_is_store;
   logic       dec_is_branch, dec_is_jump, dec_is_jal, dec_is_jr, dec_illegal;
   logic [2:0] dec_alu_op;
   logic       dec_ext_sext;
`ifdef MC_CTRL_SUBWORD_EN
   logic       dec_ld_sext;
   logic [1:0] dec_mem_width;
`endif

   // Register/immediate fields are consumed by the datapath, not here.
   logic unused_ir;
   assign unused_ir = ^ir[25:6];

   mc_ctrl_dec u_dec (
      .opcode    (ir[31:26]),
      .funct     (ir[5:0]),
      .is_rtype  (dec_is_rtype),
      .is_imm    (dec_is_imm),
      .is_load   (dec_is_load),
      .is_store  (dec_is_store),
      .is_branch (dec_is_branch),
      .is_jump   (dec_is_jump),
      .is_jal    (dec_is_jal),
      .is_jr     (dec_is_jr),
      .illegal   (dec_illegal),
      .alu_op    (dec_alu_op),
`ifdef MC_CTRL_SUBWORD_EN
      .ld_sext   (dec_ld_sext),
      .mem_width (dec_mem_width),
`endif
      .ext_sext  (dec_ext_sext)
   );

   // State, wait counter and sticky bus error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         wait_cnt_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         bus_err_q  <= bus_err_d;
      end
   end

   // Next-state and Moore outputs
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      bus_err_d  = bus_err_q;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      ext_sext   = 1'b0;
      alu_op     = ALU_ADDU;
      alu_src_b  = 1'b0;
      reg_dst    = REG_DST_RT;
      wb_sel     = WB_ALU;
      pc_sel     = PC_PC4;
`ifdef MC_CTRL_SUBWORD_EN
      ld_sext    = 1'b0;
      mem_width  = MW_WORD;
`endif
      // Extender/width selects are valid from DECODE to the end of the instruction.
      in_instr   = (state_q != ST_FETCH) && (state_q <= ST_JUMP);

      if (rst_n) begin
         ext_sext = in_instr & dec_ext_sext;
`ifdef MC_CTRL_SUBWORD_EN
         ld_sext   = in_instr & dec_ld_sext;
         mem_width = in_instr ? dec_mem_width : MW_WORD;
`endif
         case (state_q)
            ST_DECODE: begin
               if (dec_illegal)                       state_d = ST_FETCH;
               else if (dec_is_rtype || dec_is_imm)   state_d = ST_EXEC;
               else if (dec_is_load || dec_is_store)  state_d = ST_MADDR;
               else if (dec_is_branch)                state_d = ST_BRANCH;
               else                                   state_d = ST_JUMP;
            end
            ST_EXEC: begin
               alu_op    = dec_alu_op;
               alu_src_b = dec_is_imm;
               state_d   = ST_WB;
            end
            ST_WB: begin
               reg_we  = 1'b1;
               reg_dst = dec_is_rtype ? REG_DST_RD : REG_DST_RT;
               wb_sel  = dec_is_load ? WB_MEM : WB_ALU;
               state_d = ST_FETCH;
            end
            ST_MADDR: begin
               alu_op    = ALU_ADDU;
               alu_src_b = 1'b1;
               state_d   = dec_is_load ? ST_MRD : ST_MWR;
            end
            ST_MRD, ST_MWR: begin
               mem_re = (state_q == ST_MRD);
               mem_we = (state_q == ST_MWR);
               if (mem_ready) begin
                  state_d = (state_q == ST_MRD) ? ST_WB : ST_FETCH;
               end else if ((MEM_WAIT_MAX != 0) &&
                            (wait_cnt_q == CNT_W'(MEM_WAIT_MAX - 1))) begin
                  // Timeout: abandon the access, skip writeback.
                  bus_err_d = 1'b1;
                  state_d   = ST_FETCH;
               end else begin
                  wait_cnt_d = wait_cnt_q + CNT_W'(1);
               end
            end
            ST_BRANCH: begin
               alu_op  = ALU_SUBU;
               pc_we   = zero;
               pc_sel  = PC_BR;
               state_d = ST_FETCH;
            end
            ST_JUMP: begin
               pc_we  = 1'b1;
               pc_sel = dec_is_jr ? PC_JR : PC_JMP;
               if (dec_is_jal) begin
                  reg_we  = 1'b1;
                  reg_dst = REG_DST_RA;
                  wb_sel  = WB_PC4;
               end
               state_d = ST_FETCH;
            end
            // FETCH, and unreachable encodings behave as FETCH.
            default: begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               pc_sel  = PC_PC4;
               state_d = ST_DECODE;
            end
         endcase
      end
   end

   assign bus_err = bus_err_q;
   assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven per-cycle checks of mc_ctrl plus hand-written
// sequences for asynchronous reset during a write and the memory timeout.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ir;
   logic        zero;
   logic        mem_ready;
   logic        pc_we, ir_we, reg_we, mem_re, mem_we, ext_sext;
   logic [2:0]  alu_op;
   logic        alu_src_b;
   logic [1:0]  reg_dst, wb_sel, pc_sel;
   logic        bus_err;
   logic [3:0]  state;
`ifdef MC_CTRL_SUBWORD_EN
   logic        ld_sext;
   logic [1:0]  mem_width;
`endif

   always #5 clk = ~clk;

   mc_ctrl #(.MEM_WAIT_MAX(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ir        (ir),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pc_we     (pc_we),
      .ir_we     (ir_we),
      .reg_we    (reg_we),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .ext_sext  (ext_sext),
      .alu_op    (alu_op),
      .alu_src_b (alu_src_b),
      .reg_dst   (reg_dst),
      .wb_sel    (wb_sel),
      .pc_sel    (pc_sel),
`ifdef MC_CTRL_SUBWORD_EN
      .ld_sext   (ld_sext),
      .mem_width (mem_width),
`endif
      .bus_err   (bus_err),
      .state     (state)
   );

   localparam logic [31:0] I_ADDU = 32'h0022_1821;
   localparam logic [31:0] I_SUBU = 32'h0022_1823;
   localparam logic [31:0] I_ORI  = 32'h3422_8000;
   localparam logic [31:0] I_LUI  = 32'h3C01_1234;
   localparam logic [31:0] I_LW   = 32'h8C22_FFFC;
   localparam logic [31:0] I_SW   = 32'hAC22_0004;
   localparam logic [31:0] I_BEQ  = 32'h1022_0004;
   localparam logic [31:0] I_J    = 32'h0800_0010;
   localparam logic [31:0] I_JAL  = 32'h0C00_0010;
   localparam logic [31:0] I_JR   = 32'h03E0_0008;
   localparam logic [31:0] I_ILL  = 32'hFC00_0000;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_we, ir_we, reg_we, mem_re, mem_we, ext_sext;
      logic [2:0] alu_op;
      logic       alu_src_b;
      logic [1:0] reg_dst, wb_sel, pc_sel;
      logic       bus_err;
   } outs_t;

   typedef struct {
      logic        rst_n;
      logic [31:0] ir;
      logic        zero;
      logic        rdy;
      outs_t       exp;
   } vec_t;

   vec_t vecs[$];
   logic eb = 1'b0;   // expected bus_err while building the table
   int   n_chk = 0;
   int   n_pass = 0;

   function automatic outs_t mk(input logic [3:0] st, input logic pw, input logic iw,
                                input logic rw, input logic mr, input logic mw,
                                input logic sx, input logic [2:0] aop, input logic sb,
                                input logic [1:0] rd, input logic [1:0] wb,
                                input logic [1:0] ps);
      return '{st, pw, iw, rw, mr, mw, sx, aop, sb, rd, wb, ps, eb};
   endfunction

   task automatic add(input logic r, input logic [31:0] i, input logic z,
                      input logic rd, input outs_t e);
      vecs.push_back('{r, i, z, rd, e});
   endtask

   task automatic add_fetch(input logic [31:0] i, input logic rd);
      add(1'b1, i, 1'b0, rd, mk(4'd0, 1, 1, 0, 0, 0, 0, 3'd0, 0, 2'd0, 2'd0, 2'd0));
   endtask

   task automatic add_decode(input logic [31:0] i, input logic sx, input logic rd);
      add(1'b1, i, 1'b0, rd, mk(4'd1, 0, 0, 0, 0, 0, sx, 3'd0, 0, 2'd0, 2'd0, 2'd0));
   endtask

   // R-type / ori / lui: FETCH, DECODE, EXEC, WB
   task automatic add_alu(input logic [31:0] i, input logic [2:0] aop, input logic sb,
                          input logic [1:0] rd);
      add_fetch(i, 1'b0);
      add_decode(i, 1'b0, 1'b0);
      add(1'b1, i, 1'b0, 1'b0, mk(4'd2, 0, 0, 0, 0, 0, 0, aop, sb, 2'd0, 2'd0, 2'd0));
      add(1'b1, i, 1'b0, 1'b0, mk(4'd6, 0, 0, 1, 0, 0, 0, 3'd0, 0, rd, 2'd0, 2'd0));
   endtask

   task automatic add_maddr(input logic [31:0] i, input logic rd);
      add_fetch(i, rd);
      add_decode(i, 1'b1, rd);
      add(1'b1, i, 1'b0, rd, mk(4'd3, 0, 0, 0, 0, 0, 1, 3'd0, 1, 2'd0, 2'd0, 2'd0));
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   function automatic outs_t sample();
      return '{state, pc_we, ir_we, reg_we, mem_re, mem_we, ext_sext, alu_op,
               alu_src_b, reg_dst, wb_sel, pc_sel, bus_err};
   endfunction

   initial begin
      outs_t got;
      int    cnt;
      logic  done;

      rst_n = 1'b0; ir = I_ADDU; zero = 1'b0; mem_ready = 1'b0;

      // Reset held 3 cycles: everything idle
      for (int k = 0; k < 3; k++)
         add(1'b0, I_ADDU, 1'b0, 1'b0, mk(4'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 2'd0, 2'd0));
      add_alu(I_ADDU, 3'd0, 1'b0, 2'd1);
      add_alu(I_ORI,  3'd2, 1'b1, 2'd0);
      // lw with mem_ready late by 2 cycles: mem_re for 3 cycles, 7 total
      add_maddr(I_LW, 1'b0);
      add(1'b1, I_LW, 1'b0, 1'b0, mk(4'd4, 0, 0, 0, 1, 0, 1, 3'd0, 0, 2'd0, 2'd0, 2'd0));
      add(1'b1, I_LW, 1'b0, 1'b0, mk(4'd4, 0, 0, 0, 1, 0, 1, 3'd0, 0, 2'd0, 2'd0, 2'd0));
      add(1'b1, I_LW, 1'b0, 1'b1, mk(4'd4, 0, 0, 0, 1, 0, 1, 3'd0, 0, 2'd0, 2'd0, 2'd0));
      add(1'b1, I_LW, 1'b0, 1'b0, mk(4'd6, 0, 0, 1, 0, 0, 1, 3'd0, 0, 2'd0, 2'd1, 2'd0));
      // beq taken then not taken
      add_fetch(I_BEQ, 1'b0);
      add_decode(I_BEQ, 1'b1, 1'b0);
      add(1'b1, I_BEQ, 1'b1, 1'b0, mk(4'd7, 1, 0, 0, 0, 0, 1, 3'd1, 0, 2'd0, 2'd0, 2'd1));
      add_fetch(I_BEQ, 1'b0);
      add_decode(I_BEQ, 1'b1, 1'b0);
      add(1'b1, I_BEQ, 1'b0, 1'b0, mk(4'd7, 0, 0, 0, 0, 0, 1, 3'd1, 0, 2'd0, 2'd0, 2'd1));
      // jal, jr, j
      add_fetch(I_JAL, 1'b0);
      add_decode(I_JAL, 1'b0, 1'b0);
      add(1'b1, I_JAL, 1'b0, 1'b0, mk(4'd8, 1, 0, 1, 0, 0, 0, 3'd0, 0, 2'd2, 2'd2, 2'd2));
      add_fetch(I_JR, 1'b0);
      add_decode(I_JR, 1'b0, 1'b0);
      add(1'b1, I_JR, 1'b0, 1'b0, mk(4'd8, 1, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 2'd0, 2'd3));
      add_fetch(I_J, 1'b0);
      add_decode(I_J, 1'b0, 1'b0);
      add(1'b1, I_J, 1'b0, 1'b0, mk(4'd8, 1, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 2'd0, 2'd2));
      // illegal: FETCH, DECODE, FETCH (next instruction's fetch)
      add_fetch(I_ILL, 1'b0);
      add_decode(I_ILL, 1'b0, 1'b0);
      add_alu(I_SUBU, 3'd1, 1'b0, 2'd1);
      add_alu(I_LUI,  3'd3, 1'b1, 2'd0);
      // sw and lw with mem_ready already high
      add_maddr(I_SW, 1'b1);
      add(1'b1, I_SW, 1'b0, 1'b1, mk(4'd5, 0, 0, 0, 0, 1, 1, 3'd0, 0, 2'd0, 2'd0, 2'd0));
      add_maddr(I_LW, 1'b1);
      add(1'b1, I_LW, 1'b0, 1'b1, mk(4'd4, 0, 0, 0, 1, 0, 1, 3'd0, 0, 2'd0, 2'd0, 2'd0));
      add(1'b1, I_LW, 1'b0, 1'b1, mk(4'd6, 0, 0, 1, 0, 0, 1, 3'd0, 0, 2'd0, 2'd1, 2'd0));
      // sw with mem_ready stuck low: 15 write cycles then bus error
      add_maddr(I_SW, 1'b0);
      for (int k = 0; k < 15; k++)
         add(1'b1, I_SW, 1'b0, 1'b0, mk(4'd5, 0, 0, 0, 0, 1, 1, 3'd0, 0, 2'd0, 2'd0, 2'd0));
      eb = 1'b1;
      add_alu(I_ADDU, 3'd0, 1'b0, 2'd1);   // bus_err stays set
      // reset during MWR clears bus_err and drops mem_we
      add_maddr(I_SW, 1'b0);
      add(1'b1, I_SW, 1'b0, 1'b0, mk(4'd5, 0, 0, 0, 0, 1, 1, 3'd0, 0, 2'd0, 2'd0, 2'd0));
      eb = 1'b0;
      add(1'b0, I_SW, 1'b0, 1'b0, mk(4'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 2'd0, 2'd0));
      add_fetch(I_SW, 1'b0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_n = vecs[i].rst_n; ir = vecs[i].ir; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
         #1;
         got = sample();
         check($sformatf("vec%0d", i), 32'(got), 32'(vecs[i].exp));
      end

      // Asynchronous reset mid-write, away from any clock edge
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; ir = I_SW; mem_ready = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         @(negedge clk); #1;
         if (state == 4'd5) done = 1'b1;
      end
      check("reach_mwr", 32'(done), 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b0; #1;
      check("async_mem_we", 32'(mem_we), 32'd0);
      check("async_state", 32'(state), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Timeout length counted independently of the table
      cnt = 0; done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk); #1;
         if (mem_we) cnt++;
         if (cnt > 0 && state == 4'd0) done = 1'b1;
      end
      check("timeout_return", 32'(done), 32'd1);
      check("timeout_cycles", 32'(cnt), 32'd15);
      check("timeout_bus_err", 32'(bus_err), 32'd1);

`ifdef MC_CTRL_SUBWORD_EN
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; ir = 32'h9022_0000; mem_ready = 1'b1;   // lbu
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         @(negedge clk); #1;
         if (state == 4'd4) done = 1'b1;
      end
      check("lbu_reach_mrd", 32'(done), 32'd1);
      check("lbu_ld_sext", 32'(ld_sext), 32'd0);
      check("lbu_mem_width", 32'(mem_width), 32'd2);
      check("lbu_ext_sext", 32'(ext_sext), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
